// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with hazard detection and operand forwarding
// Optional feature macro: ID_EX_FWD_EN (forwarding + load-use interlock); default build forwards nothing.
module id_ex_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic        stall,
   input  logic        in_valid,
   input  logic [4:0]  in_rs,
   input  logic [4:0]  in_rt,
   input  logic [4:0]  in_rd,
   input  logic [31:0] in_rdata1,
   input  logic [31:0] in_rdata2,
   input  logic [31:0] in_imm,
   input  logic [3:0]  in_alu_op,
   input  logic        in_alu_src,
   input  logic        in_reg_dst,
   input  logic        in_reg_write,
   input  logic        in_mem_read,
   input  logic        in_mem_write,
   input  logic        in_mem_to_reg,
   input  logic        exmem_reg_write,
   input  logic [4:0]  exmem_rd,
   input  logic [31:0] exmem_result,
   input  logic        memwb_reg_write,
   input  logic [4:0]  memwb_rd,
   input  logic [31:0] memwb_wdata,
   output logic        ex_valid,
   output logic [4:0]  ex_dest,
   output logic [31:0] ex_opa,
   output logic [31:0] ex_opb,
   output logic [31:0] ex_store_data,
   output logic [3:0]  ex_alu_op,
   output logic        ex_reg_write,
   output logic        ex_mem_read,
   output logic        ex_mem_write,
   output logic        ex_mem_to_reg,
   output logic        load_use_stall,
   output logic [15:0] bubble_count
);

   logic [31:0] ex_rdata1;
   logic [31:0] ex_rdata2;
   logic [31:0] ex_imm;
   logic        ex_alu_src;
   logic [31:0] fwd_b;

`ifdef ID_EX_FWD_EN
   logic [4:0] ex_rs;
   logic [4:0] ex_rt;

   always_ff @(posedge clk) begin
      if (reset) begin
         ex_rs <= 5'd0;
         ex_rt <= 5'd0;
      end else if (!flush && !stall && !load_use_stall) begin
         ex_rs <= in_rs;
         ex_rt <= in_rt;
      end
   end

   assign load_use_stall = in_valid && ex_valid && ex_mem_read && (ex_dest != 5'd0) &&
                           ((ex_dest == in_rs) || (ex_dest == in_rt));

   // The nearer stage wins; register 0 is never forwarded.
   always_comb begin
      ex_opa = ex_rdata1;
      if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == ex_rs))
         ex_opa = exmem_result;
      else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == ex_rs))
         ex_opa = memwb_wdata;
   end

   always_comb begin
      fwd_b = ex_rdata2;
      if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == ex_rt))
         fwd_b = exmem_result;
      else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == ex_rt))
         fwd_b = memwb_wdata;
   end
`else
   logic unused_fwd;
   assign unused_fwd = ^{in_rs, in_rt, exmem_reg_write, exmem_rd, exmem_result,
                         memwb_reg_write, memwb_rd, memwb_wdata};
   assign load_use_stall = 1'b0;
   assign ex_opa = ex_rdata1;
   assign fwd_b = ex_rdata2;
`endif

   assign ex_store_data = fwd_b;
   assign ex_opb = ex_alu_src ? ex_imm : fwd_b;

   always_ff @(posedge clk) begin
      if (reset) begin
         ex_valid      <= 1'b0;
         ex_dest       <= 5'd0;
         ex_rdata1     <= 32'd0;
         ex_rdata2     <= 32'd0;
         ex_imm        <= 32'd0;
         ex_alu_op     <= 4'd0;
         ex_alu_src    <= 1'b0;
         ex_reg_write  <= 1'b0;
         ex_mem_read   <= 1'b0;
         ex_mem_write  <= 1'b0;
         ex_mem_to_reg <= 1'b0;
         bubble_count  <= 16'd0;
      end else if (flush || (!stall && load_use_stall)) begin
         // Bubble: only validity and control are cleared; data fields are don't-care.
         ex_valid      <= 1'b0;
         ex_alu_op     <= 4'd0;
         ex_reg_write  <= 1'b0;
         ex_mem_read   <= 1'b0;
         ex_mem_write  <= 1'b0;
         ex_mem_to_reg <= 1'b0;
         if (bubble_count != 16'hFFFF)
            bubble_count <= bubble_count + 16'd1;
      end else if (!stall) begin
         ex_valid      <= in_valid;
         ex_dest       <= in_reg_dst ? in_rd : in_rt;
         ex_rdata1     <= in_rdata1;
         ex_rdata2     <= in_rdata2;
         ex_imm        <= in_imm;
         ex_alu_src    <= in_alu_src;
         ex_alu_op     <= in_valid ? in_alu_op : 4'd0;
         ex_reg_write  <= in_valid && in_reg_write;
         ex_mem_read   <= in_valid && in_mem_read;
         ex_mem_write  <= in_valid && in_mem_write;
         ex_mem_to_reg <= in_valid && in_mem_to_reg;
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - randomized bench for id_ex_stage against an EX-slot reference model
// Honours ID_EX_FWD_EN the same way as the design.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        reset, flush, stall, in_valid;
   logic [4:0]  in_rs, in_rt, in_rd;
   logic [31:0] in_rdata1, in_rdata2, in_imm;
   logic [3:0]  in_alu_op;
   logic        in_alu_src, in_reg_dst, in_reg_write, in_mem_read, in_mem_write, in_mem_to_reg;
   logic        exmem_reg_write, memwb_reg_write;
   logic [4:0]  exmem_rd, memwb_rd;
   logic [31:0] exmem_result, memwb_wdata;
   logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, load_use_stall;
   logic [4:0]  ex_dest;
   logic [31:0] ex_opa, ex_opb, ex_store_data;
   logic [3:0]  ex_alu_op;
   logic [15:0] bubble_count;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk(clk), .reset(reset), .flush(flush), .stall(stall), .in_valid(in_valid),
      .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_rdata1(in_rdata1), .in_rdata2(in_rdata2),
      .in_imm(in_imm), .in_alu_op(in_alu_op), .in_alu_src(in_alu_src), .in_reg_dst(in_reg_dst),
      .in_reg_write(in_reg_write), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
      .in_mem_to_reg(in_mem_to_reg), .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
      .exmem_result(exmem_result), .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd),
      .memwb_wdata(memwb_wdata), .ex_valid(ex_valid), .ex_dest(ex_dest), .ex_opa(ex_opa),
      .ex_opb(ex_opb), .ex_store_data(ex_store_data), .ex_alu_op(ex_alu_op),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_mem_to_reg(ex_mem_to_reg), .load_use_stall(load_use_stall), .bubble_count(bubble_count)
   );

   // What the EX slot currently holds, in instruction terms.
   typedef struct {
      logic        v;
      logic [4:0]  rs, rt, dest;
      logic [31:0] rd1, rd2, imm;
      logic [3:0]  op;
      logic        src, rw, mr, mw, m2r;
      int          cnt;
   } slot_t;

   slot_t m;
   int n_checks = 0;
   int n_pass = 0;
`ifdef ID_EX_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp)
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      else
         n_pass++;
   endtask

   function automatic slot_t empty_slot();
      slot_t s;
      s.v = 0; s.rs = 0; s.rt = 0; s.dest = 0; s.rd1 = 0; s.rd2 = 0; s.imm = 0;
      s.op = 0; s.src = 0; s.rw = 0; s.mr = 0; s.mw = 0; s.m2r = 0; s.cnt = 0;
      return s;
   endfunction

   function automatic logic model_lus(slot_t s);
      if (!FWD) return 1'b0;
      return in_valid && s.v && s.mr && s.dest != 0 && (s.dest == in_rs || s.dest == in_rt);
   endfunction

   function automatic logic [31:0] model_fwd(logic [4:0] r, logic [31:0] raw);
      if (FWD && exmem_reg_write && exmem_rd != 0 && exmem_rd == r) return exmem_result;
      if (FWD && memwb_reg_write && memwb_rd != 0 && memwb_rd == r) return memwb_wdata;
      return raw;
   endfunction

   function automatic slot_t bubble(slot_t s);
      slot_t n = s;
      n.v = 0; n.rw = 0; n.mr = 0; n.mw = 0; n.m2r = 0;
      n.cnt = (s.cnt >= 65535) ? 65535 : s.cnt + 1;
      return n;
   endfunction

   function automatic slot_t model_next(slot_t s);
      slot_t n = s;
      if (reset) return empty_slot();
      if (flush) return bubble(s);
      if (stall) return s;
      if (model_lus(s)) return bubble(s);
      n.v = in_valid; n.rs = in_rs; n.rt = in_rt; n.dest = in_reg_dst ? in_rd : in_rt;
      n.rd1 = in_rdata1; n.rd2 = in_rdata2; n.imm = in_imm; n.op = in_alu_op; n.src = in_alu_src;
      n.rw = in_valid & in_reg_write; n.mr = in_valid & in_mem_read;
      n.mw = in_valid & in_mem_write; n.m2r = in_valid & in_mem_to_reg;
      return n;
   endfunction

   task automatic compare();
      logic [31:0] b;
      chk("ex_valid", {31'd0, ex_valid}, {31'd0, m.v});
      chk("ctrl", {28'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg},
          {28'd0, m.rw, m.mr, m.mw, m.m2r});
      chk("load_use_stall", {31'd0, load_use_stall}, {31'd0, model_lus(m)});
      chk("bubble_count", {16'd0, bubble_count}, m.cnt);
      if (m.v) begin
         b = model_fwd(m.rt, m.rd2);
         chk("ex_dest", {27'd0, ex_dest}, {27'd0, m.dest});
         chk("ex_alu_op", {28'd0, ex_alu_op}, {28'd0, m.op});
         chk("ex_opa", ex_opa, model_fwd(m.rs, m.rd1));
         chk("ex_store_data", ex_store_data, b);
         chk("ex_opb", ex_opb, m.src ? m.imm : b);
      end
   endtask

   // Called at a falling edge with inputs already applied.
   task automatic step(input bit do_check);
      #1;
      if (do_check) compare();
      m = model_next(m);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      reset = 0; flush = 0; stall = 0; in_valid = 0;
      in_rs = 0; in_rt = 0; in_rd = 0; in_rdata1 = 0; in_rdata2 = 0; in_imm = 0; in_alu_op = 0;
      in_alu_src = 0; in_reg_dst = 0; in_reg_write = 0; in_mem_read = 0; in_mem_write = 0;
      in_mem_to_reg = 0; exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
      memwb_reg_write = 0; memwb_rd = 0; memwb_wdata = 0;
   endtask

   task automatic random_inputs();
      reset = ($urandom_range(63) == 0);
      flush = ($urandom_range(9) == 0);
      stall = ($urandom_range(7) == 0);
      in_valid = ($urandom_range(4) != 0);
      in_rs = 5'($urandom_range(7)); in_rt = 5'($urandom_range(7)); in_rd = 5'($urandom_range(7));
      in_rdata1 = $urandom; in_rdata2 = $urandom; in_imm = $urandom; in_alu_op = 4'($urandom);
      in_alu_src = 1'($urandom); in_reg_dst = 1'($urandom); in_reg_write = 1'($urandom);
      in_mem_read = ($urandom_range(2) == 0); in_mem_write = 1'($urandom);
      in_mem_to_reg = 1'($urandom);
      exmem_reg_write = 1'($urandom); exmem_rd = 5'($urandom_range(7)); exmem_result = $urandom;
      memwb_reg_write = 1'($urandom); memwb_rd = 5'($urandom_range(7)); memwb_wdata = $urandom;
   endtask

   initial begin
      m = empty_slot();
      idle_inputs();
      @(negedge clk);
      reset = 1; flush = 1; stall = 1;
      step(1'b0);
      m = empty_slot();
      reset = 0; flush = 0; stall = 0;
      #1;
      chk("rst ex_valid", {31'd0, ex_valid}, 32'd0);
      chk("rst ex_opa", ex_opa, 32'd0);
      chk("rst ex_dest", {27'd0, ex_dest}, 32'd0);
      chk("rst bubble_count", {16'd0, bubble_count}, 32'd0);
      chk("rst load_use_stall", {31'd0, load_use_stall}, 32'd0);

      // Plain load of two operands.
      in_valid = 1; in_rdata1 = 5; in_rdata2 = 7; in_rs = 1; in_rt = 2;
      step(1'b1);
      idle_inputs();
      #1;
      chk("load ex_opa", ex_opa, 32'd5);
      chk("load ex_opb", ex_opb, 32'd7);
      chk("load ex_valid", {31'd0, ex_valid}, 32'd1);

      // EX/MEM takes precedence over MEM/WB for the same register.
      in_valid = 1; in_rs = 3; in_rdata1 = 32'h11;
      step(1'b1);
      idle_inputs();
      exmem_reg_write = 1; exmem_rd = 3; exmem_result = 32'hAA;
      memwb_reg_write = 1; memwb_rd = 3; memwb_wdata = 32'hBB;
      #1;
      chk("fwd exmem", ex_opa, FWD ? 32'hAA : 32'h11);
      exmem_reg_write = 0;
      #1;
      chk("fwd memwb", ex_opa, FWD ? 32'hBB : 32'h11);

      // Load to r4 followed by a consumer of r4.
      idle_inputs();
      in_valid = 1; in_mem_read = 1; in_reg_write = 1; in_rt = 4;
      step(1'b1);
      idle_inputs();
      in_valid = 1; in_rs = 1; in_rt = 4;
      #1;
      chk("load-use stall", {31'd0, load_use_stall}, {31'd0, FWD});
      step(1'b1);
      idle_inputs();
      #1;
      chk("load-use bubble valid", {31'd0, ex_valid}, {31'd0, !FWD});
      chk("load-use bubble count", {16'd0, bubble_count}, FWD ? 32'd1 : 32'd0);

      // Register 0 is never forwarded and never interlocks.
      in_valid = 1; in_rs = 0; in_rdata1 = 0;
      exmem_reg_write = 1; exmem_rd = 0; exmem_result = 32'hDEAD;
      step(1'b1);
      #1;
      chk("r0 ex_opa", ex_opa, 32'd0);
      idle_inputs();
      in_valid = 1; in_mem_read = 1; in_rt = 0;
      step(1'b1);
      idle_inputs();
      in_valid = 1; in_rs = 0; in_rt = 0;
      #1;
      chk("r0 no stall", {31'd0, load_use_stall}, 32'd0);

      // Flush beats stall; reset beats flush.
      in_reg_write = 1; flush = 1; stall = 1;
      step(1'b1);
      #1;
      chk("flush+stall valid", {31'd0, ex_valid}, 32'd0);
      chk("flush+stall count", {16'd0, bubble_count}, FWD ? 32'd2 : 32'd1);
      reset = 1;
      step(1'b1);
      idle_inputs();
      #1;
      chk("rst+flush ctrl", {27'd0, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg},
          32'd0);
      chk("rst+flush count", {16'd0, bubble_count}, 32'd0);

      for (int i = 0; i < 3000; i++) begin
         random_inputs();
         step(1'b1);
      end

      // Saturate the bubble counter from zero with back-to-back flushes.
      idle_inputs();
      reset = 1;
      step(1'b1);
      reset = 0; flush = 1;
      for (int i = 0; i < 65535; i++) step(1'b0);
      #1;
      chk("sat reached", {16'd0, bubble_count}, 32'h0000FFFF);
      step(1'b1);
      #1;
      chk("sat hold", {16'd0, bubble_count}, 32'h0000FFFF);
      flush = 0;
      step(1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
